// File: rtl/tpu_gemm_pkg.sv
// Shared GEMM datapath constants, pointer-width helper and the partial-sum column type.
// Holds no logic and no state.
package tpu_gemm_pkg;

  localparam int PSUM_DATA_WIDTH_DEF = 32;
  localparam int PE_SIZE_DEF         = 16;
  localparam int COL_W               = PSUM_DATA_WIDTH_DEF;

  typedef logic signed [COL_W-1:0] col_t;

  // Minimum 1 so a depth-1 structure still gets a legal pointer width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/psum_delay_line.sv
// Delays one partial-sum column (data + valid) by DELAY cycles; DELAY=0 is a wire.
// Latency DELAY cycles, no backpressure: always accepts, valids cleared by rst.
module psum_delay_line #(
  parameter int DELAY           = 1,
  parameter int PSUM_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  input  logic [PSUM_DATA_WIDTH-1:0] i_dat,
  output logic                       o_vld,
  output logic [PSUM_DATA_WIDTH-1:0] o_dat
);

  generate
    if (DELAY == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_vld    = i_vld;
      assign o_dat    = i_dat;
    end else begin : g_regs
      logic                       r_vld [DELAY];
      logic [PSUM_DATA_WIDTH-1:0] r_dat [DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) r_vld[i] <= 1'b0;
        end else begin
          r_vld[0] <= i_vld;
          for (int i = 1; i < DELAY; i++) r_vld[i] <= r_vld[i-1];
        end
      end

      // Data stages are not reset; only the valids qualify them.
      always_ff @(posedge clk) begin
        r_dat[0] <= i_dat;
        for (int i = 1; i < DELAY; i++) r_dat[i] <= r_dat[i-1];
      end

      assign o_vld = r_vld[DELAY-1];
      assign o_dat = r_dat[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/psum_deskew_buffer.sv
// De-skews staggered systolic-array psum columns into rows and queues them in a show-ahead FIFO;
// latency PE_SIZE cycles, ready/valid drain, rows dropped (sticky overflow) when full. PSUM_RELU_EN clamps negatives.
module psum_deskew_buffer
  import tpu_gemm_pkg::*;
#(
  parameter int PSUM_DATA_WIDTH = PSUM_DATA_WIDTH_DEF,
  parameter int PE_SIZE         = PE_SIZE_DEF,
  parameter int OUT_DEPTH       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PE_SIZE-1:0]                 valid_col_i,
  input  logic [PSUM_DATA_WIDTH*PE_SIZE-1:0] psum_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [PSUM_DATA_WIDTH*PE_SIZE-1:0] out_data_o,
  output logic                               full_o,
  output logic                               afull_o,
  output logic                               empty_o,
  output logic                               overflow_o,
  output logic                               skew_err_o
);

  localparam int W     = PSUM_DATA_WIDTH;
  localparam int ROW_W = PSUM_DATA_WIDTH * PE_SIZE;
  localparam int PTR_W = clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] PE_C    = CNT_W'(PE_SIZE);

  logic [PE_SIZE-1:0] w_dly_vld;
  logic [W-1:0]       w_dly_dat [PE_SIZE];
  logic [ROW_W-1:0]   w_row;

  // Column j arrives j cycles late, so it is held PE_SIZE-1-j cycles to line up with column PE_SIZE-1.
  generate
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
      psum_delay_line #(
        .DELAY           (PE_SIZE - 1 - j),
        .PSUM_DATA_WIDTH (W)
      ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .i_vld (valid_col_i[j]),
        .i_dat (psum_i[W*(PE_SIZE-1-j) +: W]),
        .o_vld (w_dly_vld[j]),
        .o_dat (w_dly_dat[j])
      );
    end
  endgenerate

  always_comb begin
    w_row = '0;
    for (int j = 0; j < PE_SIZE; j++) begin
`ifdef PSUM_RELU_EN
      w_row[W*(PE_SIZE-1-j) +: W] = w_dly_dat[j][W-1] ? '0 : w_dly_dat[j];
`else
      w_row[W*(PE_SIZE-1-j) +: W] = w_dly_dat[j];
`endif
    end
  end

  logic [ROW_W-1:0] r_mem [OUT_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overflow;
  logic             r_skew_err;

  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_free;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_skew;

  assign w_full  = (r_cnt == DEPTH_C);
  assign w_empty = (r_cnt == '0);
  assign w_free  = DEPTH_C - r_cnt;
  assign w_pop   = !w_empty && out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_dly_vld[0] && (!w_full || w_pop);
  assign w_drop  = w_dly_vld[0] && w_full && !w_pop;
  assign w_skew  = (|w_dly_vld) && !(&w_dly_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_skew_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      if (w_skew) r_skew_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_row;
  end

  assign out_valid_o = !w_empty;
  assign out_data_o  = r_mem[r_rd_ptr];
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign afull_o     = (w_free <= PE_C);
  assign overflow_o  = r_overflow;
  assign skew_err_o  = r_skew_err;

endmodule

// File: tb/tb_psum_deskew_buffer.sv
// Directed bench for psum_deskew_buffer at PE_SIZE=4, 32-bit psums, 8-row FIFO.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_psum_deskew_buffer;
  import tpu_gemm_pkg::*;

  localparam int PW = 32;
  localparam int PE = 4;
  localparam int OD = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [PE-1:0]     valid_col_i;
  logic [PW*PE-1:0]  psum_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PW*PE-1:0]  out_data_o;
  logic              full_o;
  logic              afull_o;
  logic              empty_o;
  logic              overflow_o;
  logic              skew_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  psum_deskew_buffer #(
    .PSUM_DATA_WIDTH (PW),
    .PE_SIZE         (PE),
    .OUT_DEPTH       (OD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_col_i (valid_col_i),
    .psum_i      (psum_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .full_o      (full_o),
    .afull_o     (afull_o),
    .empty_o     (empty_o),
    .overflow_o  (overflow_o),
    .skew_err_o  (skew_err_o)
  );

  function automatic logic [PW-1:0] val(input int r, input int j);
    return PW'(r * 16 + j + 1);
  endfunction

  function automatic logic [PW*PE-1:0] exp_row(input int r);
    return {val(r, 0), val(r, 1), val(r, 2), val(r, 3)};
  endfunction

  task automatic chk(input string tag, input logic [PW*PE-1:0] obs, input logic [PW*PE-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_col_i = '0;
    psum_i      = '0;
    tick();
  endtask

  // Drives cycle c of a skewed burst: column j carries row c-j.
  task automatic apply(input int c, input int nrows, input int miss_row, input int miss_col);
    valid_col_i = '0;
    psum_i      = '0;
    for (int j = 0; j < PE; j++) begin
      int r;
      r = c - j;
      if (r >= 0 && r < nrows && !(r == miss_row && j == miss_col)) begin
        valid_col_i[j]            = 1'b1;
        psum_i[PW*(PE-1-j) +: PW] = val(r, j);
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    valid_col_i = '0;
    psum_i      = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  col_t             relu_in [PE];
  logic [PW*PE-1:0] relu_exp;

  initial begin
    rst         = 1'b1;
    out_ready_i = 1'b0;
    valid_col_i = '0;
    psum_i      = '0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_empty",     empty_o,     1);
    chk("rst_full",      full_o,      0);
    chk("rst_afull",     afull_o,     0);
    chk("rst_overflow",  overflow_o,  0);
    chk("rst_skew",      skew_err_o,  0);
    rst = 1'b0;

    // Single skewed row: visible in cycle 4, not before
    for (int c = 0; c < 4; c++) begin
      apply(c, 1, -1, -1);
      if (c == 2) begin
        chk("single_valid_c3", out_valid_o, 0);
        chk("single_empty_c3", empty_o,     1);
      end
    end
    chk("single_valid_c4", out_valid_o, 1);
    chk("single_empty_c4", empty_o,     0);
    chk("single_data",     out_data_o,  exp_row(0));
    out_ready_i = 1'b1;
    idle();
    chk("single_drained", empty_o, 1);

    // Streaming 8 rows with ready held high
    do_reset();
    out_ready_i = 1'b1;
    for (int c = 0; c < 11; c++) begin
      apply(c, 8, -1, -1);
      chk("stream_full", full_o, 0);
      if (c + 1 >= 4) begin
        chk("stream_valid", out_valid_o, 1);
        chk("stream_data",  out_data_o,  exp_row(c + 1 - 4));
      end else begin
        chk("stream_idle", out_valid_o, 0);
      end
    end
    idle();
    chk("stream_empty_end", empty_o, 1);

    // Backpressure: 9 rows into an 8-deep FIFO
    do_reset();
    out_ready_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      apply(c, 9, -1, -1);
      if (c + 1 == 6)  chk("bp_afull_3rows", afull_o, 0);
      if (c + 1 == 7)  chk("bp_afull_4rows", afull_o, 1);
      if (c + 1 == 10) chk("bp_full_7rows",  full_o,  0);
      if (c + 1 == 11) begin
        chk("bp_full_8rows",   full_o,     1);
        chk("bp_overflow_pre", overflow_o, 0);
      end
    end
    chk("bp_overflow", overflow_o, 1);
    chk("bp_full_hold", full_o, 1);
    out_ready_i = 1'b1;
    for (int i = 0; i < OD; i++) begin
      chk("bp_drain_valid", out_valid_o, 1);
      chk("bp_drain_data",  out_data_o,  exp_row(i));
      idle();
    end
    chk("bp_drain_empty",  empty_o,     1);
    chk("bp_drain_novld",  out_valid_o, 0);
    chk("bp_overflow_stk", overflow_o,  1);

    // Skew error: column 2 valid missing
    do_reset();
    out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) apply(c, 1, 0, 2);
    chk("skew_flag",  skew_err_o,  1);
    chk("skew_valid", out_valid_o, 1);
    chk("skew_data",  out_data_o,  {val(0, 0), val(0, 1), 32'd0, val(0, 3)});
    idle();
    idle();
    chk("skew_sticky", skew_err_o, 1);

    // Negative values, with or without ReLU
    do_reset();
    out_ready_i = 1'b0;
    relu_in[0] = -32'sd5;
    relu_in[1] = 32'sd7;
    relu_in[2] = 32'sd0;
    relu_in[3] = -32'sd1;
`ifdef PSUM_RELU_EN
    relu_exp = {32'd0, 32'd7, 32'd0, 32'd0};
`else
    relu_exp = {32'hFFFF_FFFB, 32'd7, 32'd0, 32'hFFFF_FFFF};
`endif
    for (int j = 0; j < PE; j++) begin
      valid_col_i               = PE'(1 << j);
      psum_i                    = '0;
      psum_i[PW*(PE-1-j) +: PW] = relu_in[j];
      tick();
    end
    chk("relu_valid", out_valid_o, 1);
    chk("relu_data",  out_data_o,  relu_exp);

    // Reset mid-stream: 2 rows stored, 1 in flight, skew flag set
    do_reset();
    out_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) apply(c, 3, 0, 1);
    chk("mid_pre_empty", empty_o,    0);
    chk("mid_pre_skew",  skew_err_o, 1);
    rst         = 1'b1;
    valid_col_i = '0;
    psum_i      = '0;
    tick();
    chk("mid_rst_empty",    empty_o,     1);
    chk("mid_rst_valid",    out_valid_o, 0);
    chk("mid_rst_skew",     skew_err_o,  0);
    chk("mid_rst_overflow", overflow_o,  0);
    rst         = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("mid_post_valid", out_valid_o, 0);
    end
    chk("mid_post_empty", empty_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
